// File: rtl/wb_serial_master.sv
// wb_serial_master -- byte-stream to Wishbone bridge.
//
// Lets a host read or write the SoC address map over a byte channel
// (for example the UART RX/TX byte path). Frames, multi-byte fields LSB first:
//   read : CMD_RD A0 A1 A2 A3          -> D0 D1 D2 D3
//   write: CMD_WR A0..A3 D0..D3        -> 8'hA5
//   bad opcode or bus timeout          -> 8'hEE
// Each command runs one classic Wishbone single-beat cycle.
//
// Ports
//   wb_clk_i / wb_rst_i      clock, synchronous active-high reset
//   rx_dat_i/rx_vld_i/rx_rdy_o   command byte in  (transfer = vld & rdy)
//   tx_dat_o/tx_vld_o/tx_rdy_i   response byte out (transfer = vld & rdy)
//   wb_adr_o/wb_dat_o/wb_dat_i/wb_we_o/wb_sel_o/wb_cyc_o/wb_stb_o/wb_ack_i
//                                Wishbone initiator side
//   busy_o                       high whenever not idle
module wb_serial_master #(
  parameter int unsigned TIMEOUT = 256,
  parameter logic [7:0]  CMD_RD  = 8'h52,
  parameter logic [7:0]  CMD_WR  = 8'h57
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_dat_i,
  input  logic        rx_vld_i,
  output logic        rx_rdy_o,
  output logic [7:0]  tx_dat_o,
  output logic        tx_vld_o,
  input  logic        tx_rdy_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        busy_o
);

  // Timer counts the cycles cyc/stb are high: 0 .. TIMEOUT-1.
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  state_t        state;
  logic [1:0]    cnt;       // byte index within a field / response
  logic [1:0]    rsp_last;  // index of the final response byte
  logic          is_wr;
  logic [TW-1:0] tcnt;
  logic [31:0]   rsp;       // remaining read-data bytes, next one in [7:0]
  logic          rx_xfer;
  logic          tx_xfer;

  assign rx_xfer  = rx_vld_i & rx_rdy_o;
  assign tx_xfer  = tx_vld_o & tx_rdy_i;
  assign wb_sel_o = 4'hF;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rsp_last <= '0;
      is_wr    <= 1'b0;
      tcnt     <= '0;
      rsp      <= '0;
      rx_rdy_o <= 1'b0;
      tx_dat_o <= '0;
      tx_vld_o <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          rx_rdy_o <= 1'b1;
          if (rx_xfer) begin
            cnt    <= '0;
            busy_o <= 1'b1;
            if (rx_dat_i == CMD_RD || rx_dat_i == CMD_WR) begin
              is_wr <= (rx_dat_i == CMD_WR);
              state <= S_ADDR;
            end else begin
              rx_rdy_o <= 1'b0;
              tx_vld_o <= 1'b1;
              tx_dat_o <= 8'hEE;
              rsp_last <= 2'd0;
              state    <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (rx_xfer) begin
            wb_adr_o[{cnt, 3'b000} +: 8] <= rx_dat_i;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              if (is_wr) begin
                state <= S_DATA;
              end else begin
                rx_rdy_o <= 1'b0;
                state    <= S_BUS;
              end
            end
          end
        end

        S_DATA: begin
          if (rx_xfer) begin
            wb_dat_o[{cnt, 3'b000} +: 8] <= rx_dat_i;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              rx_rdy_o <= 1'b0;
              state    <= S_BUS;
            end
          end
        end

        S_BUS: begin
          // First BUS cycle launches the transfer; ack is only honoured while
          // the cycle is actually on the bus.
          if (!wb_cyc_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= is_wr;
            tcnt     <= '0;
          end else if (wb_ack_i) begin
            // Ack takes priority even on the last permitted cycle.
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            tx_vld_o <= 1'b1;
            cnt      <= '0;
            state    <= S_RESP;
            if (is_wr) begin
              tx_dat_o <= 8'hA5;
              rsp_last <= 2'd0;
            end else begin
              tx_dat_o <= wb_dat_i[7:0];
              rsp      <= {8'h00, wb_dat_i[31:8]};
              rsp_last <= 2'd3;
            end
          end else if (tcnt == T_LAST) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            tx_vld_o <= 1'b1;
            tx_dat_o <= 8'hEE;
            rsp_last <= 2'd0;
            cnt      <= '0;
            state    <= S_RESP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        S_RESP: begin
          if (tx_xfer) begin
            if (cnt == rsp_last) begin
              tx_vld_o <= 1'b0;
              rx_rdy_o <= 1'b1;
              busy_o   <= 1'b0;
              state    <= S_IDLE;
            end else begin
              cnt      <= cnt + 2'd1;
              tx_dat_o <= rsp[7:0];
              rsp      <= {8'h00, rsp[31:8]};
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_serial_master.sv
// Bench for wb_serial_master: frame-level reference model (expected bus
// transactions and expected response bytes in queues), a random-latency
// slave and random-ready sink, plus directed frames with literal results.
module tb_wb_serial_master;
  localparam int TO = 16;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [7:0]  rx_dat_i = '0;
  logic        rx_vld_i = 1'b0;
  logic        rx_rdy_o;
  logic [7:0]  tx_dat_o;
  logic        tx_vld_o;
  logic        tx_rdy_i = 1'b0;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o, wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic        busy_o;

  wb_serial_master #(.TIMEOUT(TO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .rx_dat_i(rx_dat_i), .rx_vld_i(rx_vld_i), .rx_rdy_o(rx_rdy_o),
    .tx_dat_o(tx_dat_o), .tx_vld_o(tx_vld_o), .tx_rdy_i(tx_rdy_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .busy_o(busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // w = wait states before ack (ack in cycle w+1), -1 = never ack.
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    int          w;
    logic [31:0] rd;
  } plan_t;

  plan_t      plan_q[$];
  plan_t      wb_log[$];
  logic [7:0] exp_tx[$];
  logic [7:0] tx_log[$];

  int nvec = 0;
  int nerr = 0;
  bit sink_hold = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- slave, sink and per-cycle compare ----------------
  plan_t       cur;
  int          run = 0;
  bit          pend = 1'b0;
  logic [7:0]  prev_dat = '0;
  logic [31:0] c_adr, c_dat;
  logic        c_we;

  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      run      = 0;
      pend     = 1'b0;
      wb_ack_i = 1'b0;
      tx_rdy_i = 1'b0;
    end else begin
      if (wb_cyc_o) begin
        if (run == 0) begin
          if (plan_q.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_wb_cycle: got adr %h expected no cycle", wb_adr_o);
            cur = '{adr: 32'h0, dat: 32'h0, we: 1'b0, w: -1, rd: 32'h0};
          end else begin
            cur = plan_q.pop_front();
          end
          wb_log.push_back('{adr: wb_adr_o, dat: wb_dat_o, we: wb_we_o, w: 0, rd: 32'h0});
          chk("wb_adr", wb_adr_o, cur.adr);
          chk("wb_we", 32'(wb_we_o), 32'(cur.we));
          if (cur.we) chk("wb_dat", wb_dat_o, cur.dat);
          c_adr = wb_adr_o; c_dat = wb_dat_o; c_we = wb_we_o;
        end else begin
          chk("wb_adr_stable", wb_adr_o, c_adr);
          chk("wb_dat_stable", wb_dat_o, c_dat);
          chk("wb_we_stable", 32'(wb_we_o), 32'(c_we));
        end
        chk("wb_stb", 32'(wb_stb_o), 32'd1);
        chk("wb_sel", 32'(wb_sel_o), 32'hF);
        chk("rx_rdy_in_bus", 32'(rx_rdy_o), 32'd0);
        chk("busy_in_bus", 32'(busy_o), 32'd1);
        wb_ack_i = (cur.w >= 0 && run == cur.w);
        wb_dat_i = wb_ack_i ? cur.rd : $urandom();
        run++;
      end else begin
        if (run != 0) chk("wb_cycle_len", 32'(run), 32'(cur.w < 0 ? TO : cur.w + 1));
        run = 0;
        chk("stb_without_cyc", 32'(wb_stb_o), 32'd0);
        // Stray acks outside a bus cycle must be ignored.
        wb_ack_i = ($urandom_range(0, 3) == 0);
        wb_dat_i = $urandom();
      end

      if (pend) begin
        chk("tx_vld_held", 32'(tx_vld_o), 32'd1);
        chk("tx_dat_stable", 32'(tx_dat_o), 32'(prev_dat));
      end
      if (tx_vld_o) begin
        chk("rx_rdy_in_resp", 32'(rx_rdy_o), 32'd0);
        chk("busy_in_resp", 32'(busy_o), 32'd1);
      end
      tx_rdy_i = sink_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (tx_vld_o && tx_rdy_i) begin
        tx_log.push_back(tx_dat_o);
        if (exp_tx.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_tx: got %h expected no byte", tx_dat_o);
        end else begin
          chk("tx_byte", 32'(tx_dat_o), 32'(exp_tx.pop_front()));
        end
      end
      pend     = tx_vld_o && !tx_rdy_i;
      prev_dat = tx_dat_o;
    end
  end

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int k;
    repeat ($urandom_range(0, 2)) @(negedge wb_clk_i);
    rx_dat_i = b;
    rx_vld_i = 1'b1;
    k = 0;
    forever begin
      ok = rx_rdy_o;
      @(negedge wb_clk_i);
      if (ok) break;
      k++;
      if (k > 500) begin
        nvec++; nerr++;
        $display("FAIL rx_accept_timeout: got no accept expected byte %h taken", b);
        break;
      end
    end
    rx_vld_i = 1'b0;
    rx_dat_i = $urandom();
  endtask

  task automatic do_frame(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] dat,
                          input int w, input logic [31:0] rd);
    if (op == 8'h52 || op == 8'h57) begin
      plan_q.push_back('{adr: adr, dat: dat, we: (op == 8'h57), w: w, rd: rd});
      if (w < 0) exp_tx.push_back(8'hEE);
      else if (op == 8'h57) exp_tx.push_back(8'hA5);
      else for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);
      send_byte(op);
      for (int i = 0; i < 4; i++) send_byte(adr[8*i +: 8]);
      if (op == 8'h57) for (int i = 0; i < 4; i++) send_byte(dat[8*i +: 8]);
    end else begin
      exp_tx.push_back(8'hEE);
      send_byte(op);
    end
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((exp_tx.size() != 0 || plan_q.size() != 0 || busy_o) && k < 3000) begin
      @(negedge wb_clk_i);
      k++;
    end
    chk({nm, "_drained"}, 32'(k < 3000), 32'd1);
  endtask

  task automatic do_reset_check(input string nm);
    chk({nm, "_cyc"}, 32'(wb_cyc_o), 32'd0);
    chk({nm, "_stb"}, 32'(wb_stb_o), 32'd0);
    chk({nm, "_busy"}, 32'(busy_o), 32'd0);
    chk({nm, "_rx_rdy"}, 32'(rx_rdy_o), 32'd0);
    chk({nm, "_tx_vld"}, 32'(tx_vld_o), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0]  op;
    logic [31:0] a, d, r;
    int          w, sel, k;

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    do_reset_check("rst");
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'hF);
    wb_rst_i = 1'b0;

    // 1. write, ack after one wait state
    wb_log.delete(); tx_log.delete();
    do_frame(8'h57, 32'h0400_0000, 32'hDEAD_BEEF, 1, 32'h0);
    drain("t1");
    chk("t1_ncyc", 32'(wb_log.size()), 32'd1);
    chk("t1_adr", wb_log[0].adr, 32'h0400_0000);
    chk("t1_dat", wb_log[0].dat, 32'hDEAD_BEEF);
    chk("t1_we", 32'(wb_log[0].we), 32'd1);
    chk("t1_ntx", 32'(tx_log.size()), 32'd1);
    chk("t1_tx", 32'(tx_log[0]), 32'hA5);

    // 2. read, three wait states
    wb_log.delete(); tx_log.delete();
    do_frame(8'h52, 32'h0800_0100, 32'h0, 3, 32'h0000_CAFE);
    drain("t2");
    chk("t2_adr", wb_log[0].adr, 32'h0800_0100);
    chk("t2_ntx", 32'(tx_log.size()), 32'd4);
    chk("t2_tx0", 32'(tx_log[0]), 32'hFE);
    chk("t2_tx1", 32'(tx_log[1]), 32'hCA);
    chk("t2_tx2", 32'(tx_log[2]), 32'h00);
    chk("t2_tx3", 32'(tx_log[3]), 32'h00);

    // 3. bad opcode, then a normal read
    wb_log.delete(); tx_log.delete();
    do_frame(8'h11, 32'h0, 32'h0, 0, 32'h0);
    drain("t3a");
    chk("t3_no_wb", 32'(wb_log.size()), 32'd0);
    chk("t3_tx", 32'(tx_log[0]), 32'hEE);
    do_frame(8'h52, 32'h1000_0040, 32'h0, 0, 32'h1234_5678);
    drain("t3b");
    chk("t3_rd_tx0", 32'(tx_log[1]), 32'h78);

    // 4. no ack -> timeout after TO cycles (length checked by the model)
    tx_log.delete();
    do_frame(8'h52, 32'h2000_0000, 32'h0, -1, 32'h0);
    drain("t4");
    chk("t4_tx", 32'(tx_log[0]), 32'hEE);

    // 5. sink stalls 10 cycles during a read response
    tx_log.delete();
    sink_hold = 1'b1;
    do_frame(8'h52, 32'h0000_0010, 32'h0, 2, 32'hA1B2_C3D4);
    k = 0;
    while (!tx_vld_o && k < 100) begin @(negedge wb_clk_i); k++; end
    chk("t5_tx_vld_seen", 32'(k < 100), 32'd1);
    repeat (10) @(negedge wb_clk_i);
    sink_hold = 1'b0;
    drain("t5");
    chk("t5_ntx", 32'(tx_log.size()), 32'd4);
    chk("t5_tx0", 32'(tx_log[0]), 32'hD4);
    chk("t5_tx3", 32'(tx_log[3]), 32'hA1);

    // Latency with a zero-wait slave: last byte at edge N
    do_frame(8'h57, 32'h0000_0020, 32'h5555_AAAA, 0, 32'h0);
    chk("lat_n_cyc", 32'(wb_cyc_o), 32'd0);
    @(negedge wb_clk_i);
    chk("lat_n1_cyc", 32'(wb_cyc_o), 32'd1);
    @(negedge wb_clk_i);
    chk("lat_n2_txvld", 32'(tx_vld_o), 32'd1);
    chk("lat_n2_cyc", 32'(wb_cyc_o), 32'd0);
    drain("lat");

    // Random frames
    for (int f = 0; f < 40; f++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      op = 8'h52;
      else if (sel < 8) op = 8'h57;
      else begin
        op = 8'($urandom_range(0, 255));
        while (op == 8'h52 || op == 8'h57) op = 8'($urandom_range(0, 255));
      end
      a = $urandom(); d = $urandom(); r = $urandom();
      sel = $urandom_range(0, 9);
      if (sel < 7)       w = $urandom_range(0, 4);
      else if (sel == 7) w = TO - 1;
      else if (sel == 8) w = -1;
      else               w = TO - 2;
      do_frame(op, a, d, w, r);
    end
    drain("rand");

    // 6a. reset in the middle of the address field
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h01);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    do_reset_check("rst_addr");
    wb_rst_i = 1'b0;
    plan_q.delete(); exp_tx.delete();

    // 6b. reset during a bus cycle
    do_frame(8'h52, 32'h3000_0000, 32'h0, -1, 32'h0);
    k = 0;
    while (!wb_cyc_o && k < 20) begin @(negedge wb_clk_i); k++; end
    chk("rst_bus_cyc_seen", 32'(wb_cyc_o), 32'd1);
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    do_reset_check("rst_bus");
    wb_rst_i = 1'b0;
    plan_q.delete(); exp_tx.delete();

    // Bridge works normally after reset
    tx_log.delete();
    do_frame(8'h52, 32'h0000_0004, 32'h0, 1, 32'h0BAD_F00D);
    drain("post_rst");
    chk("post_rst_tx0", 32'(tx_log[0]), 32'h0D);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
